// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector bench.
package seq_pkg;

    // Generator FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Default pattern, matched by the Moore_seq detector
    localparam logic [3:0] SEQ_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it
// out MSB first, repeating it a programmable number of times with an optional
// idle gap between repetitions. All outputs are registered.
//
// Handshake: start is a request sampled on every rising clk edge and accepted
// only when busy=0 (busy acts as not-ready); a request seen while busy=1 is
// dropped, not queued. pattern and repeats are captured only on acceptance.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [CNT_W-1:0]           repeats,
    output logic                       data_out,
    output logic                       data_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic [1:0]                 state_dbg
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    logic [1:0]       state;
    logic [WIDTH-1:0] pattern_reg;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] idx_dec;

    assign idx_dec   = bit_idx - 1'b1;
    assign state_dbg = state;

    // Main FSM: frame acceptance, bit shifting, repetition and gap counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pattern_reg <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            bit_idx     <= '0;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pattern_reg <= pattern;
                        rep_cnt     <= (repeats == '0) ? ONE_REP : repeats;
                        bit_idx     <= IDX_MSB;
                        data_out    <= pattern[WIDTH-1];
                        data_valid  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx != '0) begin
                        bit_idx  <= idx_dec;
                        data_out <= pattern_reg[idx_dec];
                    end else if (rep_cnt > ONE_REP) begin
                        rep_cnt <= rep_cnt - 1'b1;
                        if (GAP == 0) begin
                            // Back-to-back: next repetition starts with no bubble
                            bit_idx  <= IDX_MSB;
                            data_out <= pattern_reg[WIDTH-1];
                        end else begin
                            data_valid <= 1'b0;
                            data_out   <= 1'b0;
                            gap_cnt    <= GAP_INIT;
                            state      <= ST_GAP;
                        end
                    end else begin
                        data_valid <= 1'b0;
                        data_out   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        bit_idx    <= '0;
                        state      <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        bit_idx    <= IDX_MSB;
                        data_out   <= pattern_reg[WIDTH-1];
                        data_valid <= 1'b1;
                        state      <= ST_SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: one instance with GAP=0 and one with GAP=2.
// Expected per-cycle outputs for whole frames are pushed when a start is
// accepted; per-instance monitors pop and compare on every falling edge.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int IDX_W = 2;
    localparam int OUT_W = 4 + IDX_W;      // {data_out, data_valid, busy, done, bit_idx}
    localparam int EW    = 32 + OUT_W;     // {cycle stamp, outputs}

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       start_v = 2'b00;
    logic [WIDTH-1:0] pattern_v [2];
    logic [CNT_W-1:0] repeats_v [2];
    logic [1:0]       dout_v, dv_v, busy_v, done_v;
    logic [IDX_W-1:0] idx_v   [2];
    logic [1:0]       state_v [2];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int last_busy [2];

    // Clock and reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0)) dut_g0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]),
        .pattern(pattern_v[0]), .repeats(repeats_v[0]),
        .data_out(dout_v[0]), .data_valid(dv_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .bit_idx(idx_v[0]), .state_dbg(state_v[0])
    );

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2)) dut_g2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]),
        .pattern(pattern_v[1]), .repeats(repeats_v[1]),
        .data_out(dout_v[1]), .data_valid(dv_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .bit_idx(idx_v[1]), .state_dbg(state_v[1])
    );

    function automatic logic [OUT_W-1:0] actual(input int d);
        return {dout_v[d], dv_v[d], busy_v[d], done_v[d], idx_v[d]};
    endfunction

    // Scoreboard push: one expected output record for one absolute cycle
    task automatic push(input int d, input int c, input logic [OUT_W-1:0] v);
        logic [EW-1:0] e;
        e = {c[31:0], v};
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Reference model: build the whole frame from the pattern/repeat/gap rules
    task automatic accept(input int d, input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
        int eff;
        int gap;
        int c;
        eff = (rep == 0) ? 1 : int'(rep);
        gap = (d == 0) ? 0 : 2;
        c = cyc;
        for (int r = 0; r < eff; r++) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                push(d, c, {pat[i], 1'b1, 1'b1, 1'b0, IDX_W'(i)});
                c++;
            end
            if (r < eff - 1) begin
                for (int g = 0; g < gap; g++) begin
                    push(d, c, {1'b0, 1'b0, 1'b1, 1'b0, {IDX_W{1'b0}}});
                    c++;
                end
            end
        end
        push(d, c, {1'b0, 1'b0, 1'b0, 1'b1, {IDX_W{1'b0}}});
        last_busy[d] = c - 1;
    endtask

    // Monitor compare: the record stamped for this cycle, else an idle record
    task automatic check_out(input int d);
        logic [EW-1:0]    e;
        logic [OUT_W-1:0] want;
        logic [OUT_W-1:0] got;
        bit               found;
        want  = '0;
        found = 1'b0;
        got   = actual(d);
        while (!found && ((d == 0) ? exp_q0.size() : exp_q1.size()) > 0) begin
            e = (d == 0) ? exp_q0[0] : exp_q1[0];
            if (int'(e[EW-1:OUT_W]) < cyc) begin
                if (d == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
                compared++;
                mismatched++;
                $display("FAIL dut%0d stale_record cyc=%0d: expected record for cyc %0d never matched", d, cyc, int'(e[EW-1:OUT_W]));
            end else begin
                if (int'(e[EW-1:OUT_W]) == cyc) begin
                    want = e[OUT_W-1:0];
                    if (d == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
                found = 1'b1;
            end
        end
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL dut%0d outputs cyc=%0d {dout,valid,busy,done,idx}: got %b want %b", d, cyc, got, want);
        end
    endtask

    always @(negedge clk) check_out(0);
    always @(negedge clk) check_out(1);

    task automatic check_zero(input int d);
        compared++;
        if (actual(d) !== '0) begin
            mismatched++;
            $display("FAIL dut%0d async_reset: got %b want %b", d, actual(d), {OUT_W{1'b0}});
        end
    endtask

    // Driver: present inputs for one edge, then update the model if accepted
    task automatic step(input int d, input logic st, input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
        @(negedge clk);
        #2;
        start_v[d]   = st;
        pattern_v[d] = pat;
        repeats_v[d] = rep;
        @(posedge clk);
        #1;
        if (reset_n && st && (cyc - 1 > last_busy[d])) accept(d, pat, rep);
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) step(d, 1'b0, WIDTH'($urandom), CNT_W'($urandom));
    endtask

    // Asynchronous reset asserted mid-cycle, held two cycles with start high
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        last_busy[0] = -100;
        last_busy[1] = -100;
        #1;
        check_zero(0);
        check_zero(1);
        start_v = 2'b11;
        repeat (2) @(negedge clk);
        #2;
        start_v = 2'b00;
        reset_n = 1'b1;
    endtask

    task automatic run_suite(input int d);
        // Single frame, repeat back-to-back, repeats=0 acts as 1
        step(d, 1'b1, SEQ_PATTERN, 4'd1);  idle(d, 6);
        step(d, 1'b1, 4'b1101, 4'd2);      idle(d, 14);
        step(d, 1'b1, 4'b1010, 4'd2);      idle(d, 14);
        step(d, 1'b1, 4'b0110, 4'd0);      idle(d, 6);
        // Start held high: ignored while busy, re-accepted in the done cycle
        for (int k = 0; k < 16; k++) step(d, 1'b1, WIDTH'($urandom), 4'd1);
        idle(d, 6);
        // Reset after the second bit, then a full frame from the MSB
        step(d, 1'b1, 4'b1101, 4'd1);
        step(d, 1'b0, 4'b0000, 4'd0);
        do_reset();
        idle(d, 3);
        step(d, 1'b1, 4'b1101, 4'd1);      idle(d, 6);
        // Max repeat count
        step(d, 1'b1, 4'b1001, 4'd15);     idle(d, 100);
        // Random frames, starts during busy, inputs changing while busy
        for (int k = 0; k < 150; k++)
            step(d, ($urandom_range(0, 4) == 0), WIDTH'($urandom), CNT_W'($urandom_range(0, 5)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        last_busy[0] = -100;
        last_busy[1] = -100;
        pattern_v[0] = '0; pattern_v[1] = '0;
        repeats_v[0] = '0; repeats_v[1] = '0;
        // Power-on reset with start high: must be ignored
        start_v = 2'b11;
        repeat (2) @(negedge clk);
        #2;
        start_v = 2'b00;
        reset_n = 1'b1;
        idle(0, 3);

        run_suite(0);
        idle(0, 2);
        run_suite(1);

        // Drain outstanding expectations within a bounded number of cycles
        n = 0;
        while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 300) begin
            step(1, 1'b0, 4'b0000, 4'd0);
            n++;
        end
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d/%0d records left want 0/0", exp_q0.size(), exp_q1.size());
        end
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter that drives the bit stream consumed by the Moore_seq sequence detector. It latches a WIDTH-bit pattern on a start pulse and shifts it out MSB first, one bit per clock. It repeats the pattern a programmable number of times, with an optional idle gap between repetitions. It is used as on-chip stimulus and loopback source for the detector, and as a generic serializer for short framed words.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
CNT_W, 4, width of repeat-count input
GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin transmission; sampled on clk, honoured only when busy=0
pattern  input  WIDTH  pattern to send; latched on accepted start, ignored otherwise
repeats  input  CNT_W  number of transmissions; latched on accepted start; 0 treated as 1
data_out  output  1  serial bit, MSB of pattern first; 0 when data_valid=0
data_valid  output  1  high on every cycle data_out carries a pattern bit
busy  output  1  high from the cycle after accepted start until the last bit cycle, inclusive
done  output  1  one-cycle pulse in the cycle after the last bit
bit_idx  output  $clog2(WIDTH)  index of the bit currently on data_out; 0 when idle

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset: state=IDLE; data_out, data_valid, busy, done, bit_idx, pattern_reg, rep_cnt and gap_cnt all 0. Reset mid-transmission aborts immediately. No done pulse is issued.
- All outputs are registered.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - On an edge with start=1: pattern_reg<=pattern; rep_cnt<=(repeats==0 ? 1 : repeats); bit_idx<=WIDTH-1; data_out<=pattern[WIDTH-1]; data_valid<=1; busy<=1; go to SHIFT.
  - Latency from the start-sampling edge to the first bit is 1 cycle.
- SHIFT:
  - Each edge with bit_idx>0: bit_idx<=bit_idx-1; data_out<=pattern_reg[bit_idx-1].
  - At bit_idx==0 with rep_cnt>1 and GAP==0: rep_cnt<=rep_cnt-1; reload bit_idx<=WIDTH-1; data_out<=pattern_reg[WIDTH-1]. No bubble between repetitions.
  - At bit_idx==0 with rep_cnt>1 and GAP>0: rep_cnt<=rep_cnt-1; data_valid<=0; data_out<=0; gap_cnt<=GAP-1; go to GAP. busy stays 1.
  - At bit_idx==0 with rep_cnt==1: data_valid<=0; data_out<=0; busy<=0; done<=1; bit_idx<=0; go to IDLE.
- GAP:
  - Holds data_valid=0 for exactly GAP cycles.
  - When gap_cnt==0: bit_idx<=WIDTH-1; data_out<=pattern_reg[WIDTH-1]; data_valid<=1; go to SHIFT.
  - Otherwise gap_cnt decrements.
- done: high for exactly one cycle; cleared on the next edge.
- Start during busy=1: ignored. No queuing, and pattern_reg is unaffected.
- Start in the done cycle: busy=0 and state=IDLE, so start is accepted. The new first bit appears on the next cycle, giving back-to-back frames with a one-cycle bubble.
- Pattern or repeats changing while busy: no effect.
- Total valid cycles per frame: WIDTH*rep. busy cycles: WIDTH*rep + GAP*(rep-1).
- rep_cnt is CNT_W bits wide. The maximum is 2^CNT_W-1 repetitions, with no wrap.

Decomposition:
- Shared package seq_pkg:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2)
  - default pattern constant SEQ_PATTERN=4'b1101, also used by the detector bench.
- No sub-module. The counters and shift mux are small enough to stay flat.
- A loopback top, seq_loopback_top, instantiating seq_pattern_gen and Moore_seq, is for verification only.

Test Plan:
- Reset: reset_n=0 for 2 cycles with start=1 -> all outputs 0, start ignored. After release, outputs remain 0 until start is sampled.
- Single frame: pattern=4'b1101, repeats=1, GAP=0, start pulse -> data_out=1,1,0,1 on 4 consecutive valid cycles; bit_idx=3,2,1,0; busy high 4 cycles; done high on the 5th cycle.
- Repeat back-to-back: pattern=4'b1101, repeats=2, GAP=0 -> 8 valid bits 11011101 with no gap, done on the 9th cycle. In loopback the Moore_seq detector asserts seq_detected twice.
- Gap insertion: GAP=2, pattern=4'b1010, repeats=2 -> 1010, two cycles with data_valid=0 and data_out=0, then 1010; busy high 10 cycles.
- Boundary: repeats=0 behaves as repeats=1. Start held high throughout the frame is ignored while busy; it is re-accepted in the done cycle, and the next frame starts on the cycle after.
- Reset mid-frame: assert reset_n=0 after the 2nd bit of a 1101 frame -> outputs 0 immediately (asynchronous), no done pulse. After release the block is idle and the next start sends the full frame from the MSB.
